spline_sequencer: RTL
=====================

Name: spline_sequencer

Overview:
- Controller for the `spline` interpolator datapath. It owns that datapath's `data_x`, `data_y` and `enable` inputs.
- Collects N waypoint samples (x, y) over a valid/ready stream and packs them into the spline's input vectors.
- Enables the spline, waits a fixed settle time, then snapshots the 10*(N-1) approximation bytes.
- Streams the snapshot out one byte per handshake to the lane-change trajectory consumer.

Parameters:
- N, 6: number of waypoints. Legal range 2..26.
- SETTLE_CYCLES, 4: cycles `spl_enable` is held before the snapshot. Must be >=1.

Ports:
- clock: in, 1. Single clock domain; all state updates on its rising edge.
- reset: in, 1. Synchronous, active-high.
- start: in, 1. Begins a new trajectory; honoured only in IDLE.
- in_valid: in, 1. Waypoint sample valid.
- in_ready: out, 1. Sequencer can accept a sample.
- in_x: in, 8. Waypoint x.
- in_y: in, 8. Waypoint f(x).
- spl_data_x: out, N*8. Packed x vector to the spline.
- spl_data_y: out, N*8. Packed y vector to the spline.
- spl_enable: out, 1. Spline enable.
- spl_approx: in, 10*(N-1)*8. Spline approximation vector.
- out_valid: out, 1. Output byte valid.
- out_ready: in, 1. Consumer accepts the byte.
- out_data: out, 8. Approximation byte.
- out_index: out, 8. Index of `out_data` within the approximation, 0..10*(N-1)-1.
- out_last: out, 1. High with the final byte.
- busy: out, 1. High in any state other than IDLE.
- done: out, 1. One-cycle pulse after the final byte is accepted.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: in_ready, spl_data_x, spl_data_y, spl_enable, out_valid, out_data, out_index, out_last, busy, done.
  - Sample counter, settle counter and snapshot register all 0.
  - Reset in any state aborts the run within one cycle. No partial output follows.
- States: IDLE, LOAD, SETTLE, STREAM, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD. The sample counter is cleared, and spl_data_x/spl_data_y are cleared to 0.
- LOAD:
  - in_ready=1 and busy=1.
  - On in_valid&&in_ready, in_x is written to spl_data_x[k*8+:8] and in_y to spl_data_y[k*8+:8], where k is the arrival order 0..N-1. k then increments.
  - Gaps in in_valid are allowed.
  - start is ignored.
  - On the N-th handshake -> SETTLE. From the next cycle: in_ready=0, spl_enable=1, settle counter = SETTLE_CYCLES.
- SETTLE:
  - spl_enable=1. The counter decrements each cycle.
  - At the edge where the counter equals 1:
    - spl_approx is captured into the snapshot.
    - spl_enable drops to 0.
    - state -> STREAM, with out_valid=1 and out_index=0.
  - Net effect: out_valid first rises exactly SETTLE_CYCLES cycles after spl_enable first rises.
- STREAM:
  - out_data = snapshot[out_index*8+:8].
  - out_last = (out_index == 10*(N-1)-1).
  - On out_valid&&out_ready: out_index increments. If out_last was set, instead -> DONE with out_valid=0.
  - While out_ready=0, out_valid, out_data and out_index hold stable.
  - Changes on spl_approx after the snapshot have no effect.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then -> IDLE.
  - spl_data_x/spl_data_y retain their values until the next start.
- start in LOAD, SETTLE, STREAM or DONE is ignored. It is not queued.
- Width rules:
  - Sample counter is ceil(log2(N+1)) bits.
  - Index is 8 bits; the N<=26 limit keeps 10*(N-1) <= 250.
  - All arithmetic is unsigned.

Test Plan:
1. Reset. Assert reset for 2 cycles in each of IDLE, LOAD and STREAM -> the next cycle all outputs are 0 and busy=0. After start, a full run completes normally.
2. Load packing. N=6; start, then feed x=6,10,6,6,2,2 and y=0,4,34,64,104,136 with in_valid deasserted for 1 cycle between each pair.
   - Expect spl_data_x=48'h02_02_06_06_0A_06 and spl_data_y=48'h88_68_40_22_04_00.
   - spl_enable rises the cycle after the 6th handshake; in_ready=0 from then on.
3. Settle timing and stream. Use SETTLE_CYCLES=4 and a stub spline driving byte m = m+1.
   - out_valid rises exactly 4 cycles after spl_enable rises; spl_enable falls in the same cycle.
   - With out_ready=1: 50 bytes with values 1..50 and out_index 0..49.
   - out_last is high only at index 49; done pulses once, on the cycle after the last transfer.
4. Backpressure and snapshot isolation. Toggle out_ready pseudo-randomly, and change the stub to 8'hFF after the snapshot.
   - Held bytes stay stable while out_ready=0.
   - All 50 values are still 1..50, in order, with none dropped or duplicated.
5. Ignored controls.
   - Pulse start during LOAD and during STREAM -> no state or count change.
   - Drive in_valid in IDLE -> in_ready=0 and the vectors are unchanged.
   - Drive in_valid during STREAM -> spl_data_x/y are unchanged.
6. Reset mid-stream. Assert reset at out_index=20 -> the next cycle out_valid=0 and state=IDLE. A fresh run with the same data produces indices 0..49 from the start.

Source files
------------

// File: rtl/spline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spline_sequencer
//  Purpose  : Controller for the spline interpolator datapath. Collects N
//             (x, y) waypoints over a valid/ready stream, packs them into the
//             spline input vectors, enables the spline for SETTLE_CYCLES,
//             snapshots the 10*(N-1) approximation bytes and streams them out
//             one byte per handshake.
//  Ports    : clock, reset          - clock, synchronous active-high reset
//             start                 - begin a trajectory (IDLE only)
//             in_valid/in_ready     - waypoint handshake, in_x / in_y data
//             spl_data_x/y          - packed waypoint vectors to the spline
//             spl_enable            - spline enable
//             spl_approx            - spline approximation vector
//             out_valid/out_ready   - output byte handshake
//             out_data/out_index    - byte and its position in the snapshot
//             out_last              - final byte marker
//             busy, done            - status; done pulses once per run
//  Revision : 1.0 - initial release
// ============================================================================
module spline_sequencer #(
    parameter int N             = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_x,
    input  logic [7:0]            in_y,
    output logic [N*8-1:0]        spl_data_x,
    output logic [N*8-1:0]        spl_data_y,
    output logic                  spl_enable,
    input  logic [10*(N-1)*8-1:0] spl_approx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [7:0]            out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int NB = 10 * (N - 1);
    localparam int CW = $clog2(N + 1);
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [7:0] LAST_IDX = 8'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [NB*8-1:0]   snap_q,   snap_d;
    logic [N*8-1:0]    dx_q,     dx_d;
    logic [N*8-1:0]    dy_q,     dy_d;
    logic [7:0]        idx_q,    idx_d;
    logic [7:0]        byte_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            snap_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            snap_q   <= snap_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        snap_d   = snap_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        idx_d    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                end
            end

            S_LOAD: begin
                // in_ready is high for the whole of LOAD, so in_valid alone
                // marks a handshake.
                if (in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_q == CW'(k)) begin
                            dx_d[k*8 +: 8] = in_x;
                            dy_d[k*8 +: 8] = in_y;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d  = S_SETTLE;
                        settle_d = SW'(SETTLE_CYCLES);
                    end
                end
            end

            S_SETTLE: begin
                // Counter enters at SETTLE_CYCLES, so the capture edge is the
                // SETTLE_CYCLES-th edge with the spline enabled.
                settle_d = settle_q - SW'(1);
                if (settle_q == SW'(1)) begin
                    snap_d   = spl_approx;
                    state_d  = S_STREAM;
                    idx_d    = '0;
                    settle_d = '0;
                end
            end

            S_STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte selection from the snapshot
    always_comb begin
        byte_sel = '0;
        for (int k = 0; k < NB; k++) begin
            if (idx_q == 8'(k)) begin
                byte_sel = snap_q[k*8 +: 8];
            end
        end
    end

    // Outputs are decoded from state so that all of them read 0 in IDLE
    // and immediately after reset.
    assign in_ready   = (state_q == S_LOAD);
    assign spl_enable = (state_q == S_SETTLE);
    assign out_valid  = (state_q == S_STREAM);
    assign out_data   = (state_q == S_STREAM) ? byte_sel : 8'd0;
    assign out_index  = idx_q;
    assign out_last   = (state_q == S_STREAM) && (idx_q == LAST_IDX);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign spl_data_x = dx_q;
    assign spl_data_y = dy_q;

endmodule
`default_nettype wire
